// File: rtl/alu_pipe_pkg.sv
// Shared types for the alu_pipe execute unit: op codes, FSM states
// and the M-extension op classifier.
package alu_pipe_pkg;

   typedef enum logic [4:0] {
      OP_ADD    = 5'h00,
      OP_SUB    = 5'h01,
      OP_SLT    = 5'h02,
      OP_SLTU   = 5'h03,
      OP_XOR    = 5'h04,
      OP_OR     = 5'h05,
      OP_AND    = 5'h06,
      OP_SLL    = 5'h07,
      OP_SRL    = 5'h08,
      OP_SRA    = 5'h09,
      OP_MUL    = 5'h10,
      OP_MULH   = 5'h11,
      OP_MULHSU = 5'h12,
      OP_MULHU  = 5'h13,
      OP_DIV    = 5'h14,
      OP_DIVU   = 5'h15,
      OP_REM    = 5'h16,
      OP_REMU   = 5'h17
   } alu_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

   function automatic logic is_mdu_op(input logic [4:0] op);
      return op[4:3] == 2'b10;
   endfunction

endpackage

// File: rtl/alu_mdu_iter.sv
// alu_mdu_iter: iterative shift-add multiplier / restoring divider,
// one bit per cycle on magnitudes with sign fixup on the last step.
module alu_mdu_iter
   import alu_pipe_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            i_start,
   input  logic [4:0]      i_op,
   input  logic [XLEN-1:0] i_a,
   input  logic [XLEN-1:0] i_b,
   output logic            o_done,
   output logic [XLEN-1:0] o_result
);
   localparam int CW = $clog2(XLEN);

   logic              r_run;
   logic              r_neg;
   logic              r_is_div;
   logic              r_hi_sel;
   logic [CW-1:0]     r_cnt;
   logic [XLEN-1:0]   r_hi;
   logic [XLEN-1:0]   r_lo;
   logic [XLEN-1:0]   r_b;

   logic              w_a_sgn;
   logic              w_b_sgn;
   logic              w_is_div;
   logic              w_hi_sel;
   logic              w_neg;
   logic [XLEN-1:0]   w_a_mag;
   logic [XLEN-1:0]   w_b_mag;
   logic [XLEN:0]     w_sum;
   logic [XLEN:0]     w_rs;
   logic              w_ge;
   logic [XLEN-1:0]   w_diff;
   logic [XLEN-1:0]   w_hi_n;
   logic [XLEN-1:0]   w_lo_n;
   logic [XLEN-1:0]   w_q;
   logic [XLEN-1:0]   w_r;
   logic [2*XLEN-1:0] w_prod;
   logic [2*XLEN-1:0] w_prod_f;

   assign w_is_div = i_op[2];
   assign w_a_sgn  = i_a[XLEN-1] &
                     ((i_op == OP_MULH) | (i_op == OP_MULHSU) |
                      (i_op == OP_DIV)  | (i_op == OP_REM));
   assign w_b_sgn  = i_b[XLEN-1] &
                     ((i_op == OP_MULH) | (i_op == OP_DIV) |
                      (i_op == OP_REM));
   // remainder follows the dividend; everything else follows a^b
   assign w_neg    = (i_op == OP_REM) ? w_a_sgn : (w_a_sgn ^ w_b_sgn);
   assign w_hi_sel = (i_op == OP_MULH)  | (i_op == OP_MULHSU) |
                     (i_op == OP_MULHU) | (i_op == OP_REM) |
                     (i_op == OP_REMU);
   assign w_a_mag  = w_a_sgn ? -i_a : i_a;
   assign w_b_mag  = w_b_sgn ? -i_b : i_b;

   assign w_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
   assign w_rs   = {r_hi, r_lo[XLEN-1]};
   assign w_ge   = (w_rs >= {1'b0, r_b});
   assign w_diff = w_rs[XLEN-1:0] - r_b;

   always_comb begin
      if (r_is_div) begin
         w_hi_n = w_ge ? w_diff : w_rs[XLEN-1:0];
         w_lo_n = {r_lo[XLEN-2:0], w_ge};
      end else begin
         w_hi_n = w_sum[XLEN:1];
         w_lo_n = {w_sum[0], r_lo[XLEN-1:1]};
      end
   end

   assign w_prod   = {w_hi_n, w_lo_n};
   assign w_prod_f = r_neg ? -w_prod : w_prod;
   assign w_q      = r_neg ? -w_lo_n : w_lo_n;
   assign w_r      = r_neg ? -w_hi_n : w_hi_n;

   always_comb begin
      if (r_is_div) begin
         o_result = r_hi_sel ? w_r : w_q;
      end else begin
         o_result = r_hi_sel ? w_prod_f[2*XLEN-1:XLEN]
                             : w_prod_f[XLEN-1:0];
      end
   end

   assign o_done = r_run & (r_cnt == CW'(XLEN-1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_run    <= 1'b0;
         r_neg    <= 1'b0;
         r_is_div <= 1'b0;
         r_hi_sel <= 1'b0;
         r_cnt    <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_b      <= '0;
      end else if (flush) begin
         r_run <= 1'b0;
         r_cnt <= '0;
      end else if (i_start) begin
         r_run    <= 1'b1;
         r_cnt    <= '0;
         r_hi     <= '0;
         r_lo     <= w_a_mag;
         r_b      <= w_b_mag;
         r_neg    <= w_neg;
         r_is_div <= w_is_div;
         r_hi_sel <= w_hi_sel;
      end else if (r_run) begin
         r_hi  <= w_hi_n;
         r_lo  <= w_lo_n;
         r_cnt <= r_cnt + CW'(1);
         if (o_done) begin
            r_run <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: registered, handshaked RV32I/M execute unit.
// RV32M ops need ALU_PIPE_MDU_EN; without it they return 0 in one cycle.
module alu_pipe
   import alu_pipe_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [4:0]       alu_op,
   input  logic [XLEN-1:0]  operand_a,
   input  logic [XLEN-1:0]  operand_b,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  alu_data,
   output logic [TAG_W-1:0] out_tag,
   output logic             busy
);
   localparam int SHW = $clog2(XLEN);

   state_e           r_state;
   state_e           w_state_nxt;
   logic [XLEN-1:0]  r_data;
   logic [TAG_W-1:0] r_tag;
   logic             w_accept;
   logic             w_iter;
   logic [XLEN-1:0]  w_base;
   logic [XLEN-1:0]  w_quick;
   logic [SHW-1:0]   w_shamt;
   logic             w_lt;
   logic             w_ltu;

   assign in_ready  = !flush &
                      ((r_state == IDLE) | ((r_state == DONE) & out_ready));
   assign w_accept  = in_valid & in_ready;
   assign out_valid = (r_state == DONE);
   assign alu_data  = r_data;
   assign out_tag   = r_tag;

   assign w_shamt = operand_b[SHW-1:0];
   assign w_lt    = $signed(operand_a) < $signed(operand_b);
   assign w_ltu   = operand_a < operand_b;

   always_comb begin
      w_base = '0;
      case (alu_op)
         OP_ADD:  w_base = operand_a + operand_b;
         OP_SUB:  w_base = operand_a - operand_b;
         OP_SLT:  w_base = {{(XLEN-1){1'b0}}, w_lt};
         OP_SLTU: w_base = {{(XLEN-1){1'b0}}, w_ltu};
         OP_XOR:  w_base = operand_a ^ operand_b;
         OP_OR:   w_base = operand_a | operand_b;
         OP_AND:  w_base = operand_a & operand_b;
         OP_SLL:  w_base = operand_a << w_shamt;
         OP_SRL:  w_base = operand_a >> w_shamt;
         OP_SRA:  w_base = $unsigned($signed(operand_a) >>> w_shamt);
         default: w_base = '0;
      endcase
   end

`ifdef ALU_PIPE_MDU_EN
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   logic            w_div_op;
   logic            w_b_zero;
   logic            w_ovf;
   logic            w_special;
   logic            w_mdu_start;
   logic            w_mdu_done;
   logic [XLEN-1:0] w_mdu_res;

   assign w_div_op  = is_mdu_op(alu_op) & alu_op[2];
   assign w_b_zero  = (operand_b == '0);
   assign w_ovf     = ((alu_op == OP_DIV) | (alu_op == OP_REM)) &
                      (operand_a == MIN_NEG) & (operand_b == '1);
   assign w_special = w_div_op & (w_b_zero | w_ovf);
   assign w_iter    = is_mdu_op(alu_op) & !w_special;
   assign w_mdu_start = w_accept & w_iter;
   assign busy      = (r_state == BUSY);

   // bit 1 separates remainder (REM/REMU) from quotient (DIV/DIVU)
   always_comb begin
      w_quick = w_base;
      if (w_special) begin
         if (alu_op[1]) begin
            w_quick = w_b_zero ? operand_a : '0;
         end else begin
            w_quick = w_b_zero ? '1 : operand_a;
         end
      end
   end

   alu_mdu_iter #(
      .XLEN (XLEN)
   ) u_mdu (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .i_start  (w_mdu_start),
      .i_op     (alu_op),
      .i_a      (operand_a),
      .i_b      (operand_b),
      .o_done   (w_mdu_done),
      .o_result (w_mdu_res)
   );
`else
   assign w_iter  = 1'b0;
   assign w_quick = w_base;
   assign busy    = 1'b0;
`endif

   always_comb begin
      w_state_nxt = r_state;
      if (flush) begin
         w_state_nxt = IDLE;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) w_state_nxt = w_iter ? BUSY : DONE;
            end
`ifdef ALU_PIPE_MDU_EN
            BUSY: begin
               if (w_mdu_done) w_state_nxt = DONE;
            end
`endif
            DONE: begin
               if (w_accept) begin
                  w_state_nxt = w_iter ? BUSY : DONE;
               end else if (out_ready) begin
                  w_state_nxt = IDLE;
               end
            end
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_data  <= '0;
         r_tag   <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_tag <= in_tag;
            if (!w_iter) r_data <= w_quick;
         end
`ifdef ALU_PIPE_MDU_EN
         else if ((r_state == BUSY) && w_mdu_done && !flush) begin
            r_data <= w_mdu_res;
         end
`endif
      end
   end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: random and directed checks of alu_pipe against a
// plain-arithmetic reference model.
module tb_alu_pipe;

`ifdef ALU_PIPE_MDU_EN
   localparam bit MDU_EN = 1'b1;
`else
   localparam bit MDU_EN = 1'b0;
`endif
   localparam logic [31:0] MINV = 32'h8000_0000;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  alu_op;
   logic [31:0] operand_a;
   logic [31:0] operand_b;
   logic [4:0]  in_tag;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] alu_data;
   logic [4:0]  out_tag;
   logic        busy;

   int n_vec = 0;
   int n_err = 0;

   alu_pipe #(
      .XLEN  (32),
      .TAG_W (5)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .alu_op    (alu_op),
      .operand_a (operand_a),
      .operand_b (operand_b),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .alu_data  (alu_data),
      .out_tag   (out_tag),
      .busy      (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_alu(input logic [4:0] op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
      int sa;
      int sb;
      logic [31:0] r;
`ifdef ALU_PIPE_MDU_EN
      longint la;
      longint lb;
      logic [63:0] p;
`endif
      sa = a;
      sb = b;
      r = 0;
`ifdef ALU_PIPE_MDU_EN
      la = sa;
      lb = sb;
      p = 0;
`endif
      case (op)
         5'h00: r = a + b;
         5'h01: r = a - b;
         5'h02: r = (sa < sb) ? 1 : 0;
         5'h03: r = (a < b) ? 1 : 0;
         5'h04: r = a ^ b;
         5'h05: r = a | b;
         5'h06: r = a & b;
         5'h07: r = a << b[4:0];
         5'h08: r = a >> b[4:0];
         5'h09: r = 32'(sa >>> b[4:0]);
`ifdef ALU_PIPE_MDU_EN
         5'h10: begin p = 64'(la * lb); r = p[31:0]; end
         5'h11: begin p = 64'(la * lb); r = p[63:32]; end
         5'h12: begin p = 64'(la * longint'({32'h0, b})); r = p[63:32]; end
         5'h13: begin p = {32'h0, a} * {32'h0, b}; r = p[63:32]; end
         5'h14: r = (b == 0) ? '1 :
                    (a == MINV && b == '1) ? a : 32'(sa / sb);
         5'h15: r = (b == 0) ? '1 : a / b;
         5'h16: r = (b == 0) ? a :
                    (a == MINV && b == '1) ? 0 : 32'(sa % sb);
         5'h17: r = (b == 0) ? a : a % b;
`endif
         default: r = 0;
      endcase
      return r;
   endfunction

   function automatic int exp_lat(input logic [4:0] op,
                                  input logic [31:0] a,
                                  input logic [31:0] b);
      if (!MDU_EN || op[4:3] != 2'b10) return 1;
      if (op >= 5'h14 && b == 0) return 1;
      if ((op == 5'h14 || op == 5'h16) && a == MINV && b == '1) return 1;
      return 33;
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'h1;
         2: return 32'hFFFF_FFFF;
         3: return MINV;
         4: return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   task automatic put(input logic [4:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [4:0] tag);
      in_valid  = 1'b1;
      alu_op    = op;
      operand_a = a;
      operand_b = b;
      in_tag    = tag;
   endtask

   task automatic do_op(input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] tag,
                        input int stall);
      logic [31:0] exp_d;
      int lat;
      int nb;
      int el;
      exp_d = ref_alu(op, a, b);
      el = exp_lat(op, a, b);
      @(negedge clk);
      out_ready = (stall == 0);
      put(op, a, b, tag);
      chk("rdy", 32'(in_ready), 1);
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      alu_op    = 5'($urandom);
      operand_a = $urandom;
      operand_b = $urandom;
      in_tag    = 5'($urandom);
      lat = 1;
      nb = 0;
      while (!out_valid && lat < 200) begin
         if (busy) nb++;
         @(posedge clk);
         #1;
         lat++;
      end
      chk("lat", 32'(lat), 32'(el));
      chk("busy_cnt", 32'(nb), 32'(el - 1));
      chk("data", alu_data, exp_d);
      chk("tag", 32'(out_tag), 32'(tag));
      for (int s = 0; s < stall; s++) begin
         @(posedge clk);
         #1;
         chk("hold_d", alu_data, exp_d);
         chk("hold_v", 32'(out_valid), 1);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("drain", 32'(out_valid), 0);
   endtask

   logic [4:0]  ops [0:20] = '{5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05,
                               5'h06, 5'h07, 5'h08, 5'h09, 5'h10, 5'h11,
                               5'h12, 5'h13, 5'h14, 5'h15, 5'h16, 5'h17,
                               5'h0A, 5'h18, 5'h1F};
   logic [31:0] q_d [8];
   logic [4:0]  q_t [8];

   initial begin
      logic [4:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] d1;
      logic [31:0] d2;
      int n;

      rst_n = 1'b0;
      flush = 1'b0;
      in_valid = 1'b0;
      alu_op = '0;
      operand_a = '0;
      operand_b = '0;
      in_tag = '0;
      out_ready = 1'b1;
      #12;
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_data", alu_data, 0);
      chk("rst_tag", 32'(out_tag), 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_rdy", 32'(in_ready), 1);

      do_op(5'h00, 32'hFFFF_FFFF, 32'h1, 5'h0A, 0);
      do_op(5'h02, 32'hFFFF_FFFF, 32'h1, 5'h01, 0);
      do_op(5'h03, 32'hFFFF_FFFF, 32'h1, 5'h02, 0);
      do_op(5'h09, MINV, 32'd31, 5'h03, 0);
      do_op(5'h01, 32'h5, 32'h7, 5'h04, 0);
      do_op(5'h07, 32'h1, 32'h21, 5'h05, 0);
      do_op(5'h08, MINV, 32'h3F, 5'h06, 1);
      do_op(5'h0A, 32'h1234, 32'h5678, 5'h07, 0);
      do_op(5'h10, MINV, 32'h2, 5'h08, 0);
      do_op(5'h13, MINV, 32'h2, 5'h09, 0);
      do_op(5'h11, MINV, 32'h2, 5'h0B, 0);
      do_op(5'h14, 32'h7, 32'h0, 5'h0C, 0);
      do_op(5'h16, 32'h7, 32'h0, 5'h0D, 0);
      do_op(5'h14, MINV, 32'hFFFF_FFFF, 5'h0E, 0);
      do_op(5'h16, MINV, 32'hFFFF_FFFF, 5'h0F, 0);
      do_op(5'h14, 32'hFFFF_FFF9, 32'h2, 5'h10, 0);
      do_op(5'h16, 32'hFFFF_FFF9, 32'h2, 5'h11, 2);

      // back-to-back single-cycle ops
      @(negedge clk);
      out_ready = 1'b1;
      for (int i = 0; i <= 8; i++) begin
         if (i > 0) begin
            chk("b2b_v", 32'(out_valid), 1);
            chk("b2b_d", alu_data, q_d[i-1]);
            chk("b2b_t", 32'(out_tag), 32'(q_t[i-1]));
         end
         if (i < 8) begin
            op = 5'($urandom_range(0, 9));
            a = pick();
            b = pick();
            q_d[i] = ref_alu(op, a, b);
            q_t[i] = 5'(i + 20);
            put(op, a, b, q_t[i]);
            chk("b2b_r", 32'(in_ready), 1);
            @(negedge clk);
         end
      end
      in_valid = 1'b0;
      @(negedge clk);
      chk("b2b_end", 32'(out_valid), 0);

      // backpressure then same-edge handoff
      out_ready = 1'b0;
      d1 = ref_alu(5'h04, 32'hA5A5_0F0F, 32'h0FF0_1234);
      d2 = ref_alu(5'h05, 32'h1200_0000, 32'h0000_0034);
      put(5'h04, 32'hA5A5_0F0F, 32'h0FF0_1234, 5'h15);
      @(negedge clk);
      put(5'h05, 32'h1200_0000, 32'h0000_0034, 5'h16);
      for (int i = 0; i < 5; i++) begin
         chk("bp_v", 32'(out_valid), 1);
         chk("bp_d", alu_data, d1);
         chk("bp_t", 32'(out_tag), 32'h15);
         chk("bp_rdy", 32'(in_ready), 0);
         @(negedge clk);
      end
      out_ready = 1'b1;
      #1;
      chk("hand_rdy", 32'(in_ready), 1);
      @(negedge clk);
      in_valid = 1'b0;
      chk("hand_v", 32'(out_valid), 1);
      chk("hand_d", alu_data, d2);
      chk("hand_t", 32'(out_tag), 32'h16);
      @(negedge clk);
      chk("hand_end", 32'(out_valid), 0);

      // flush after ten cycles, with a request presented in that cycle
      out_ready = 1'b0;
      put(5'h10, 32'h1234, 32'h5678, 5'h03);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (9) @(negedge clk);
      chk("fl_pre_b", 32'(busy), 32'(MDU_EN));
      chk("fl_pre_v", 32'(out_valid), 32'(!MDU_EN));
      flush = 1'b1;
      put(5'h00, 32'h1, 32'h2, 5'h07);
      #1;
      chk("fl_rdy", 32'(in_ready), 0);
      @(negedge clk);
      flush = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      chk("fl_v", 32'(out_valid), 0);
      chk("fl_b", 32'(busy), 0);
      n = 0;
      repeat (40) begin
         @(negedge clk);
         if (out_valid) n++;
      end
      chk("fl_quiet", 32'(n), 0);

      // reset while an op is in flight or held
      out_ready = 1'b0;
      put(MDU_EN ? 5'h14 : 5'h00, 32'd100, 32'd7, 5'h19);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mr_v", 32'(out_valid), 0);
      chk("mr_b", 32'(busy), 0);
      chk("mr_d", alu_data, 0);
      chk("mr_t", 32'(out_tag), 0);
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      n = 0;
      repeat (40) begin
         @(negedge clk);
         if (out_valid) n++;
      end
      chk("mr_quiet", 32'(n), 0);
      do_op(5'h00, 32'd3, 32'd4, 5'h1A, 0);

      // randomized ops with random backpressure
      for (int i = 0; i < 80; i++) begin
         op = ops[$urandom_range(0, 20)];
         a = pick();
         b = pick();
         if (op == 5'h14 && $urandom_range(0, 3) == 0) begin
            a = 32'hFFFF_FFF9;
            b = 32'h2;
         end
         do_op(op, a, b, 5'($urandom), int'($urandom_range(0, 2)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
